// File: rtl/fixed_point_vec_adder_if.sv
// Handshake and data bundle for the lane-vector fixed-point adder.
// The master side supplies operand vectors and accepts results; the slave side is the adder.
interface fixed_point_vec_adder_if #(
  parameter int LANES = 32,
  parameter int A_W   = 8,
  parameter int B_W   = 16,
  parameter int OUT_W = 16
);

  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*A_W-1:0]   a_vec;
  logic [LANES*B_W-1:0]   b_vec;
  logic                   sub;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*OUT_W-1:0] sum_vec;
  logic [LANES-1:0]       ovf;
  logic                   busy;

  modport master (
    output in_valid, a_vec, b_vec, sub, out_ready,
    input  in_ready, out_valid, sum_vec, ovf, busy
  );

  modport slave (
    input  in_valid, a_vec, b_vec, sub, out_ready,
    output in_ready, out_valid, sum_vec, ovf, busy
  );

endinterface

// File: rtl/fixed_point_vec_adder.sv
// Lane-vector fixed-point adder/subtractor.
// Captures an A-format and a B-format vector, aligns both to the output format and adds or
// subtracts PAR lanes per cycle, with per-lane overflow flags and optional saturation.
module fixed_point_vec_adder #(
  parameter int LANES    = 32,
  parameter int PAR      = 8,
  parameter int A_W      = 8,
  parameter int A_FRAC   = 7,
  parameter int B_W      = 16,
  parameter int B_FRAC   = 14,
  parameter int OUT_W    = 16,
  parameter int OUT_FRAC = 14,
  parameter int SAT      = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fixed_point_vec_adder_if.slave bus
);

  localparam int BEATS  = LANES / PAR;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int EW     = OUT_W + 2;
  localparam int A_SH   = OUT_FRAC - A_FRAC;
  localparam int B_SH   = OUT_FRAC - B_FRAC;

  // Representable output range, expressed at the extended width so the compare is exact.
  localparam logic signed [EW-1:0] OUT_MAX = {3'b000, {(OUT_W-1){1'b1}}};
  localparam logic signed [EW-1:0] OUT_MIN = {3'b111, {(OUT_W-1){1'b0}}};

  localparam logic [OUT_W-1:0] SAT_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_NEG = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                 state_q;
  logic [BEAT_W-1:0]      beat_q;
  logic [BEAT_W-1:0]      beat_d;
  logic                   lastBeat;
  logic [LANES*A_W-1:0]   aVec_q;
  logic [LANES*B_W-1:0]   bVec_q;
  logic                   sub_q;
  logic [LANES*OUT_W-1:0] sumVec_q;
  logic [LANES-1:0]       ovf_q;
  logic                   inReady_q;
  logic                   outValid_q;
  logic                   busy_q;

  // Each entry holds {overflow flag, OUT_W-bit result} for one lane of the current beat.
  logic [OUT_W:0]         laneOut [PAR];

  // One lane: align both operands, add or subtract at OUT_W+2 bits, flag and clamp/wrap.
  function automatic logic [OUT_W:0] laneCalc(
    input logic [A_W-1:0] a,
    input logic [B_W-1:0] b,
    input logic           s
  );
    logic signed [EW-1:0] ae;
    logic signed [EW-1:0] be;
    logic signed [EW-1:0] r;
    logic                 o;
    logic [OUT_W-1:0]     res;
    ae  = {{(EW-A_W){a[A_W-1]}}, a};
    be  = {{(EW-B_W){b[B_W-1]}}, b};
    ae  = ae <<< A_SH;
    be  = be <<< B_SH;
    r   = s ? (ae - be) : (ae + be);
    o   = (r > OUT_MAX) || (r < OUT_MIN);
    res = r[OUT_W-1:0];
    if (o && (SAT != 0)) begin
      res = r[EW-1] ? SAT_NEG : SAT_POS;
    end
    return {o, res};
  endfunction

  // Results for the PAR lanes selected by the current beat, taken from the captured operands.
  always_comb begin
    for (int p = 0; p < PAR; p++) begin
      laneOut[p] = laneCalc(aVec_q[(int'(beat_q) * PAR + p) * A_W +: A_W],
                            bVec_q[(int'(beat_q) * PAR + p) * B_W +: B_W],
                            sub_q);
    end
  end

  // Beat bookkeeping: detect the final beat and form the following beat index.
  always_comb begin
    lastBeat = (beat_q == BEAT_W'(BEATS - 1));
    beat_d   = beat_q + BEAT_W'(1);
  end

  // Control FSM with registered handshake outputs; also captures operands and writes results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      aVec_q     <= '0;
      bVec_q     <= '0;
      sub_q      <= 1'b0;
      sumVec_q   <= '0;
      ovf_q      <= '0;
      inReady_q  <= 1'b1;
      outValid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            aVec_q    <= bus.a_vec;
            bVec_q    <= bus.b_vec;
            sub_q     <= bus.sub;
            beat_q    <= '0;
            state_q   <= COMPUTE;
            inReady_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        COMPUTE: begin
          for (int p = 0; p < PAR; p++) begin
            sumVec_q[(int'(beat_q) * PAR + p) * OUT_W +: OUT_W] <= laneOut[p][OUT_W-1:0];
            ovf_q[int'(beat_q) * PAR + p]                       <= laneOut[p][OUT_W];
          end
          if (lastBeat) begin
            state_q    <= DONE;
            outValid_q <= 1'b1;
          end else begin
            beat_q <= beat_d;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q    <= IDLE;
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
            busy_q     <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          outValid_q <= 1'b0;
          inReady_q  <= 1'b1;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = inReady_q;
  assign bus.out_valid = outValid_q;
  assign bus.sum_vec   = sumVec_q;
  assign bus.ovf       = ovf_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_fixed_point_vec_adder.sv
// Directed bench for the lane-vector adder: one saturating instance, one wrapping instance
// and one single-beat instance (PAR == LANES) all fed from the same stimulus.
module tb_fixed_point_vec_adder;

  localparam int LANES = 32;

  logic clk;
  logic rst_n;
  logic inValid;
  logic sub;
  logic outReady;
  logic [LANES*8-1:0]  aVec;
  logic [LANES*16-1:0] bVec;

  logic [LANES*16-1:0] expS;
  logic [LANES*16-1:0] expW;
  logic [LANES-1:0]    expOvf;

  int checks;
  int failures;

  fixed_point_vec_adder_if #(.LANES(LANES), .A_W(8), .B_W(16), .OUT_W(16)) ifS ();
  fixed_point_vec_adder_if #(.LANES(LANES), .A_W(8), .B_W(16), .OUT_W(16)) ifW ();
  fixed_point_vec_adder_if #(.LANES(LANES), .A_W(8), .B_W(16), .OUT_W(16)) ifP ();

  assign ifS.in_valid  = inValid;
  assign ifS.a_vec     = aVec;
  assign ifS.b_vec     = bVec;
  assign ifS.sub       = sub;
  assign ifS.out_ready = outReady;
  assign ifW.in_valid  = inValid;
  assign ifW.a_vec     = aVec;
  assign ifW.b_vec     = bVec;
  assign ifW.sub       = sub;
  assign ifW.out_ready = outReady;
  assign ifP.in_valid  = inValid;
  assign ifP.a_vec     = aVec;
  assign ifP.b_vec     = bVec;
  assign ifP.sub       = sub;
  assign ifP.out_ready = outReady;

  fixed_point_vec_adder #(.LANES(LANES), .PAR(8), .SAT(1)) dutS (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifS.slave)
  );

  fixed_point_vec_adder #(.LANES(LANES), .PAR(8), .SAT(0)) dutW (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifW.slave)
  );

  fixed_point_vec_adder #(.LANES(LANES), .PAR(LANES), .SAT(1)) dutP (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifP.slave)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the directed sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clearVectors();
    aVec   = '0;
    bVec   = '0;
    expS   = '0;
    expW   = '0;
    expOvf = '0;
  endtask

  task automatic setLane(input int l, input logic [7:0] a, input logic [15:0] b,
                         input logic [15:0] eS, input logic [15:0] eW, input logic o);
    aVec[l*8 +: 8]   = a;
    bVec[l*16 +: 16] = b;
    expS[l*16 +: 16] = eS;
    expW[l*16 +: 16] = eW;
    expOvf[l]        = o;
  endtask

  task automatic loadVector1();
    clearVectors();
    setLane(0,  8'h40, 16'h2000, 16'h4000, 16'h4000, 1'b0);
    setLane(1,  8'h7F, 16'h7FFF, 16'h7FFF, 16'hBF7F, 1'b1);
    setLane(2,  8'h80, 16'h8000, 16'h8000, 16'h4000, 1'b1);
    setLane(3,  8'h80, 16'h2000, 16'hE000, 16'hE000, 1'b0);
    setLane(4,  8'h01, 16'h7F7F, 16'h7FFF, 16'h7FFF, 1'b0);
    setLane(5,  8'h01, 16'h7F80, 16'h7FFF, 16'h8000, 1'b1);
    setLane(6,  8'h80, 16'hC000, 16'h8000, 16'h8000, 1'b0);
    setLane(7,  8'h80, 16'hBFFF, 16'h8000, 16'h7FFF, 1'b1);
    setLane(9,  8'h20, 16'h0234, 16'h1234, 16'h1234, 1'b0);
    setLane(17, 8'hFF, 16'h0100, 16'h0080, 16'h0080, 1'b0);
    setLane(31, 8'h01, 16'h0001, 16'h0081, 16'h0081, 1'b0);
  endtask

  task automatic loadVector2();
    clearVectors();
    setLane(0,  8'h40, 16'h2000, 16'h0000, 16'h0000, 1'b0);
    setLane(1,  8'h80, 16'h7FFF, 16'h8000, 16'h4001, 1'b1);
    setLane(2,  8'h7F, 16'h8000, 16'h7FFF, 16'hBF80, 1'b1);
    setLane(3,  8'h00, 16'h0001, 16'hFFFF, 16'hFFFF, 1'b0);
    setLane(8,  8'h00, 16'h8001, 16'h7FFF, 16'h7FFF, 1'b0);
    setLane(26, 8'h10, 16'h0100, 16'h0700, 16'h0700, 1'b0);
  endtask

  // Present the current vectors for one accept edge; leaves the bench #1 after that edge.
  task automatic applyStimulus(input logic s);
    @(negedge clk);
    sub     = s;
    inValid = 1'b1;
    checkOutput("ready_before_accept", ifS.in_ready, 1);
    @(posedge clk);
    #1;
    inValid = 1'b0;
    checkOutput("ready_after_accept", ifS.in_ready, 0);
    checkOutput("busy_after_accept", ifS.busy, 1);
  endtask

  task automatic waitResult();
    int cyc;
    int pCyc;
    cyc  = 0;
    pCyc = 0;
    while (ifS.out_valid !== 1'b1 && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      if (pCyc == 0 && ifP.out_valid === 1'b1) pCyc = cyc;
    end
    checkOutput("latency_par8", cyc, 4);
    checkOutput("latency_par32", pCyc, 1);
    checkOutput("wrap_valid", ifW.out_valid, 1);
  endtask

  task automatic checkResults(input string tag);
    checkOutput({tag, "_sum_sat"},  ifS.sum_vec, expS);
    checkOutput({tag, "_ovf_sat"},  ifS.ovf,     expOvf);
    checkOutput({tag, "_sum_wrap"}, ifW.sum_vec, expW);
    checkOutput({tag, "_ovf_wrap"}, ifW.ovf,     expOvf);
    checkOutput({tag, "_sum_par"},  ifP.sum_vec, expS);
    checkOutput({tag, "_ovf_par"},  ifP.ovf,     expOvf);
    checkOutput({tag, "_ready"},    ifS.in_ready, 0);
  endtask

  task automatic releaseResult(input string tag);
    @(negedge clk);
    outReady = 1'b1;
    @(posedge clk);
    #1;
    outReady = 1'b0;
    checkOutput({tag, "_valid_cleared"}, ifS.out_valid, 0);
    checkOutput({tag, "_ready_back"},    ifS.in_ready,  1);
    checkOutput({tag, "_busy_cleared"},  ifS.busy,      0);
    checkOutput({tag, "_par_idle"},      ifP.in_ready,  1);
    checkOutput({tag, "_sum_kept"},      ifS.sum_vec,   expS);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    inValid  = 1'b0;
    sub      = 1'b0;
    outReady = 1'b0;
    clearVectors();

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("rst_valid", ifS.out_valid, 0);
    checkOutput("rst_sum", ifS.sum_vec, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_ready", ifS.in_ready, 1);
    checkOutput("post_rst_busy", ifS.busy, 0);
    checkOutput("post_rst_valid", ifS.out_valid, 0);
    checkOutput("post_rst_ovf", ifS.ovf, 0);
    checkOutput("post_rst_sum_wrap", ifW.sum_vec, 0);

    // Vector 1 (add); operands and sub are disturbed while computing.
    loadVector1();
    applyStimulus(1'b0);
    aVec = ~aVec;
    bVec = ~bVec;
    sub  = 1'b1;
    waitResult();
    checkResults("v1");

    // Hold in DONE with out_ready low and stray in_valid pulses.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      inValid = (k % 2 == 0) && (k < 9);
      aVec    = ~aVec;
      sub     = ~sub;
      checkOutput("hold_valid", ifS.out_valid, 1);
      checkOutput("hold_ready", ifS.in_ready, 0);
      checkOutput("hold_sum", ifS.sum_vec, expS);
      checkOutput("hold_ovf", ifS.ovf, expOvf);
    end
    inValid = 1'b0;
    releaseResult("v1");

    // Vector 2 (subtract).
    loadVector2();
    applyStimulus(1'b1);
    waitResult();
    checkResults("v2");
    releaseResult("v2");

    // Abort vector 1 with reset while beat 2 is pending.
    loadVector1();
    applyStimulus(1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_valid", ifS.out_valid, 0);
    checkOutput("abort_sum", ifS.sum_vec, 0);
    checkOutput("abort_ovf", ifS.ovf, 0);
    checkOutput("abort_busy", ifS.busy, 0);
    checkOutput("abort_par_valid", ifP.out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fresh vector after release completes normally.
    loadVector2();
    applyStimulus(1'b1);
    waitResult();
    checkResults("v3");
    releaseResult("v3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
